// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side request/response bundle for the two-port RAM arbiter
interface ram_port_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_we;
  logic [1:0]   req_lock;
  logic [2:0]   req_addr0;
  logic [2:0]   req_addr1;
  logic [127:0] req_wdata0;
  logic [127:0] req_wdata1;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_rdata;
  logic [15:0]  acc_cnt0;
  logic [15:0]  acc_cnt1;
  modport slave (
    input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata, acc_cnt0, acc_cnt1
  );
  modport master (
    output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata, acc_cnt0, acc_cnt1
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-requester RAM port arbiter with grant locking and 1-cycle read response
module ram_port_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus,
  output logic                ram_wr_en,
  output logic [2:0]          ram_addr,
  output logic [127:0]        ram_data_in,
  input  logic [127:0]        ram_data_out
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t            r_state, w_state_nx;
  logic              r_owner, w_owner_nx;
  logic              r_prio, w_prio_nx;
  logic [NREQ-1:0]   w_gnt;
  logic [NREQ-1:0]   r_rsp_valid;
  logic              w_sel, w_any;
  logic [2:0]        r_last_addr;
  logic [15:0]       r_cnt0, r_cnt1;
  // grant is forced off while reset is asserted so nothing reaches the RAM
  always_comb begin
    w_gnt = '0;
    if (!rst_n) w_gnt = '0;
    else if (r_state == LOCKED) w_gnt[r_owner] = bus.req_valid[r_owner];
    else if (bus.req_valid[r_prio]) w_gnt[r_prio] = 1'b1;
    else w_gnt[!r_prio] = bus.req_valid[!r_prio];
    w_sel = w_gnt[1];
    w_any = |w_gnt;
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_prio_nx = r_prio;
    if (r_state == IDLE) begin
      if (w_any) begin
        w_prio_nx = !w_sel;
        if (bus.req_lock[w_sel]) begin
          w_state_nx = LOCKED;
          w_owner_nx = w_sel;
        end
      end
    end else if (!bus.req_lock[r_owner] && (w_any || !bus.req_valid[r_owner])) begin
      w_state_nx = IDLE;
      w_prio_nx = !r_owner;
    end
  end
  assign bus.req_ready = w_gnt;
  assign ram_addr      = w_any ? (w_sel ? bus.req_addr1 : bus.req_addr0) : r_last_addr;
  assign ram_data_in   = w_any ? (w_sel ? bus.req_wdata1 : bus.req_wdata0) : '0;
  assign ram_wr_en     = w_any & bus.req_we[w_sel];
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = |r_rsp_valid ? ram_data_out : '0;
  assign bus.acc_cnt0  = r_cnt0;
  assign bus.acc_cnt1  = r_cnt1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_prio      <= 1'b0;
      r_rsp_valid <= '0;
      r_last_addr <= '0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_owner     <= w_owner_nx;
      r_prio      <= w_prio_nx;
      r_rsp_valid <= w_gnt & ~bus.req_we;
      if (w_any) r_last_addr <= ram_addr;
      if (w_gnt[0] && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt[1] && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vector table plus hand sequences for locking, reset and counter saturation
module tb_ram_port_arbiter;
  localparam logic [127:0] DA = {8{16'hA5A5}};
  localparam logic [127:0] DB = {8{16'h5B5B}};
  localparam logic [127:0] DC = {8{16'hC3C3}};
  typedef struct {
    logic [1:0]   v, we, lk;
    logic [2:0]   a0, a1;
    logic [1:0]   rdy;
    logic         wr;
    logic [2:0]   addr;
    logic [1:0]   rsp;
    logic [127:0] rd;
    logic [15:0]  c0, c1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic ram_wr_en;
  logic [2:0] ram_addr;
  logic [127:0] ram_data_in, ram_data_out;
  logic [127:0] mem [8];
  int n_chk = 0;
  int n_fail = 0;
  vec_t tv [22];
  ram_port_arbiter_if bus();
  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 8; i++) mem[i] = 128'(i);
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [2:0] a0, input logic [2:0] a1);
    bus.req_valid = v;
    bus.req_we = we;
    bus.req_lock = lk;
    bus.req_addr0 = a0;
    bus.req_addr1 = a1;
  endtask
  initial begin
    tv[0]  = '{2'b11, 2'b11, 2'b00, 3'd3, 3'd5, 2'b01, 1'b1, 3'd3, 2'b00, 128'd0, 16'd1, 16'd0};
    tv[1]  = '{2'b10, 2'b11, 2'b00, 3'd3, 3'd5, 2'b10, 1'b1, 3'd5, 2'b00, 128'd0, 16'd1, 16'd1};
    tv[2]  = '{2'b00, 2'b00, 2'b00, 3'd3, 3'd5, 2'b00, 1'b0, 3'd5, 2'b00, 128'd0, 16'd1, 16'd1};
    tv[3]  = '{2'b01, 2'b00, 2'b00, 3'd3, 3'd5, 2'b01, 1'b0, 3'd3, 2'b01, DA,     16'd2, 16'd1};
    tv[4]  = '{2'b00, 2'b00, 2'b00, 3'd3, 3'd5, 2'b00, 1'b0, 3'd3, 2'b00, 128'd0, 16'd2, 16'd1};
    tv[5]  = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b10, 1'b0, 3'd2, 2'b10, 128'd2, 16'd2, 16'd2};
    tv[6]  = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b01, 1'b0, 3'd1, 2'b01, 128'd1, 16'd3, 16'd2};
    tv[7]  = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b10, 1'b0, 3'd2, 2'b10, 128'd2, 16'd3, 16'd3};
    tv[8]  = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b01, 1'b0, 3'd1, 2'b01, 128'd1, 16'd4, 16'd3};
    tv[9]  = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b10, 1'b0, 3'd2, 2'b10, 128'd2, 16'd4, 16'd4};
    tv[10] = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b01, 1'b0, 3'd1, 2'b01, 128'd1, 16'd5, 16'd4};
    tv[11] = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b10, 1'b0, 3'd2, 2'b10, 128'd2, 16'd5, 16'd5};
    tv[12] = '{2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 2'b01, 1'b0, 3'd1, 2'b01, 128'd1, 16'd6, 16'd5};
    tv[13] = '{2'b11, 2'b11, 2'b10, 3'd0, 3'd6, 2'b10, 1'b1, 3'd6, 2'b00, 128'd0, 16'd6, 16'd6};
    tv[14] = '{2'b11, 2'b11, 2'b10, 3'd0, 3'd6, 2'b10, 1'b1, 3'd6, 2'b00, 128'd0, 16'd6, 16'd7};
    tv[15] = '{2'b11, 2'b11, 2'b00, 3'd0, 3'd6, 2'b10, 1'b1, 3'd6, 2'b00, 128'd0, 16'd6, 16'd8};
    tv[16] = '{2'b11, 2'b11, 2'b00, 3'd0, 3'd6, 2'b01, 1'b1, 3'd0, 2'b00, 128'd0, 16'd7, 16'd8};
    tv[17] = '{2'b01, 2'b01, 2'b01, 3'd4, 3'd6, 2'b01, 1'b1, 3'd4, 2'b00, 128'd0, 16'd8, 16'd8};
    tv[18] = '{2'b00, 2'b01, 2'b01, 3'd4, 3'd6, 2'b00, 1'b0, 3'd4, 2'b00, 128'd0, 16'd8, 16'd8};
    tv[19] = '{2'b10, 2'b10, 2'b01, 3'd4, 3'd6, 2'b00, 1'b0, 3'd4, 2'b00, 128'd0, 16'd8, 16'd8};
    tv[20] = '{2'b10, 2'b10, 2'b00, 3'd4, 3'd6, 2'b00, 1'b0, 3'd4, 2'b00, 128'd0, 16'd8, 16'd8};
    tv[21] = '{2'b10, 2'b10, 2'b00, 3'd4, 3'd6, 2'b10, 1'b1, 3'd6, 2'b00, 128'd0, 16'd8, 16'd9};
    rst_n = 1'b0;
    bus.req_wdata0 = DA;
    bus.req_wdata1 = DB;
    drive(2'b11, 2'b11, 2'b00, 3'd3, 3'd5);
    #2;
    chk("reset ready", 128'(bus.req_ready), 128'(2'b00));
    chk("reset wr_en", 128'(ram_wr_en), 128'(1'b0));
    chk("reset rsp_valid", 128'(bus.rsp_valid), 128'(2'b00));
    chk("reset cnt0", 128'(bus.acc_cnt0), 128'(16'd0));
    chk("reset cnt1", 128'(bus.acc_cnt1), 128'(16'd0));
    chk("reset addr", 128'(ram_addr), 128'(3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].v, tv[i].we, tv[i].lk, tv[i].a0, tv[i].a1);
      #1;
      chk($sformatf("v%0d ready", i), 128'(bus.req_ready), 128'(tv[i].rdy));
      chk($sformatf("v%0d wr_en", i), 128'(ram_wr_en), 128'(tv[i].wr));
      chk($sformatf("v%0d addr", i), 128'(ram_addr), 128'(tv[i].addr));
      chk($sformatf("v%0d din", i), ram_data_in,
          tv[i].rdy == 2'b01 ? DA : tv[i].rdy == 2'b10 ? DB : 128'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 128'(bus.rsp_valid), 128'(tv[i].rsp));
      if (tv[i].rsp != 2'b00) chk($sformatf("v%0d rdata", i), bus.rsp_rdata, tv[i].rd);
      chk($sformatf("v%0d cnt0", i), 128'(bus.acc_cnt0), 128'(tv[i].c0));
      chk($sformatf("v%0d cnt1", i), 128'(bus.acc_cnt1), 128'(tv[i].c1));
    end
    // write then read the same address on the next cycle
    bus.req_wdata0 = DC;
    drive(2'b01, 2'b01, 2'b00, 3'd7, 3'd0);
    @(posedge clk);
    #1;
    drive(2'b01, 2'b00, 2'b00, 3'd7, 3'd0);
    @(posedge clk);
    #1;
    chk("raw rsp_valid", 128'(bus.rsp_valid), 128'(2'b01));
    chk("raw rdata", bus.rsp_rdata, DC);
    // reset right after a read is accepted kills its response
    drive(2'b10, 2'b00, 2'b00, 3'd0, 3'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst mid-read rsp_valid", 128'(bus.rsp_valid), 128'(2'b00));
    chk("rst mid-read ready", 128'(bus.req_ready), 128'(2'b00));
    chk("rst mid-read cnt1", 128'(bus.acc_cnt1), 128'(16'd0));
    chk("rst mid-read addr", 128'(ram_addr), 128'(3'd0));
    chk("rst mid-read din", ram_data_in, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 2'b10, 2'b10, 3'd0, 3'd6);
    @(posedge clk);
    #1;
    drive(2'b11, 2'b11, 2'b10, 3'd0, 3'd6);
    #1;
    chk("lock hold ready", 128'(bus.req_ready), 128'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("rst locked ready", 128'(bus.req_ready), 128'(2'b00));
    chk("rst locked wr_en", 128'(ram_wr_en), 128'(1'b0));
    chk("rst locked cnt1", 128'(bus.acc_cnt1), 128'(16'd0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 3'd0, 3'd6);
    #1;
    chk("first grant after reset", 128'(bus.req_ready), 128'(2'b01));
    drive(2'b01, 2'b01, 2'b00, 3'd2, 3'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt0 at fffe", 128'(bus.acc_cnt0), 128'(16'hFFFE));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cnt0 sat %0d", k), 128'(bus.acc_cnt0), 128'(16'hFFFF));
    end
    chk("cnt1 idle", 128'(bus.acc_cnt1), 128'(16'd0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request pending; bit i = requester i.
REQ-005 req_we  input  2  per-requester write (1) / read (0) select.
REQ-006 req_lock  input  2  per-requester grant hold request.
REQ-007 req_addr0, req_addr1  input  3 each  per-requester word address.
REQ-008 req_wdata0, req_wdata1  input  128 each  per-requester write data.
REQ-009 req_ready  output  2  per-requester accept; transfer occurs when valid&ready at a clock edge.
REQ-010 rsp_valid  output  2  per-requester read-data valid strobe.
REQ-011 rsp_rdata  output  128  shared read data, meaningful only when a rsp_valid bit is 1.
REQ-012 ram_wr_en  output  1  RAM write enable.
REQ-013 ram_addr  output  3  RAM address.
REQ-014 ram_data_in  output  128  RAM write data.
REQ-015 ram_data_out  input  128  RAM read data; reflects address sampled at previous edge.
REQ-016 acc_cnt0, acc_cnt1  output  16 each  per-requester accepted-transfer counters.

Function
REQ-017 At most one req_ready bit SHALL be 1 per cycle; req_ready SHALL be 0 for any requester whose req_valid is 0.
REQ-018 Arbitration SHALL be round-robin via a 1-bit priority pointer prio: requester prio wins if valid, else the other wins if valid.
REQ-019 After every accepted transfer by requester i without hold, prio SHALL become 1-i at that edge.
REQ-020 FSM states IDLE and LOCKED; IDLE->LOCKED when a transfer by requester i is accepted with req_lock[i]=1, recording owner=i.
REQ-021 In LOCKED, only owner SHALL be granted; other requester's req_ready stays 0 regardless of prio.
REQ-022 LOCKED->IDLE at the edge of an owner transfer with req_lock[owner]=0, or any cycle where req_valid[owner]=0 and req_lock[owner]=0; prio then = 1-owner.
REQ-023 ram_addr, ram_data_in SHALL combinationally follow the granted requester; with no grant, ram_addr holds previous value (registered last_addr) and ram_data_in=0.
REQ-024 ram_wr_en SHALL equal granted requester's req_we ANDed with grant; 0 when no grant.
REQ-025 Read latency exactly 1 cycle: accepted read by i at edge N -> rsp_valid[i]=1 during cycle N+1 with rsp_rdata=ram_data_out.
REQ-026 rsp_valid SHALL be a 1-cycle pulse per read; writes produce no rsp_valid; no backpressure on responses.
REQ-027 Back-to-back reads SHALL be supported every cycle; rsp_valid may stay 1 on consecutive cycles.
REQ-028 Read same cycle-after a write to same address SHALL return newly written data (RAM ordering, no bypass needed).
REQ-029 acc_cnt[i] SHALL increment by 1 per accepted transfer by i, saturating at 16'hFFFF.
REQ-030 Simultaneous valid from both in IDLE: prio winner granted; loser held with ready=0 until granted, inputs must stay stable.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state=IDLE, prio=0, owner=0, rsp_valid=0, acc_cnt0=acc_cnt1=0, last_addr=0.
REQ-032 During reset req_ready=0 and ram_wr_en=0; a read accepted before reset assertion SHALL produce no rsp_valid after release.
REQ-033 First grant after reset release SHALL go to requester 0 if both valid.

Verification
REQ-034 Both valid, writes addr 3 data A / addr 5 data B -> req0 granted cycle 1, req1 cycle 2; RAM holds A@3, B@5; acc_cnt0=acc_cnt1=1.
REQ-035 req0 read addr 3 after above -> rsp_valid=2'b01 next cycle, rsp_rdata=A; rsp_valid[1] stays 0.
REQ-036 Both continuously valid for 8 cycles -> grants alternate 0,1,0,1...; each acc_cnt=4.
REQ-037 req1 lock=1 for 3 transfers with req0 valid throughout -> req0 ready=0 for those 3 cycles, granted the cycle after lock drops.
REQ-038 Assert rst_n=0 mid-read and in LOCKED -> all outputs per REQ-031 immediately; after release, req0 wins first contention.
REQ-039 Force acc_cnt0 to 16'hFFFE, issue 3 transfers -> counter reads 16'hFFFF and remains.
